// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: snoop inputs, drain stream and status outputs of the writeback trace buffer.
// The slave modport is the buffer side; the master modport drives captures and consumes records.
interface wb_trace_buffer_if #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16,
  parameter int DROP_W  = 8
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic               trace_enable;
  logic               clear;
  logic               ctrl_writeEnable;
  logic [4:0]         ctrl_writeReg;
  logic [31:0]        data_writeReg;
  logic               trace_valid;
  logic               trace_ready;
  logic [CYCLE_W-1:0] trace_cycle;
  logic [4:0]         trace_reg;
  logic [31:0]        trace_data;
  logic [FILL_W-1:0]  fill_level;
  logic [DROP_W-1:0]  drop_count;
  logic               overflow;

  modport slave (
    input  trace_enable, clear, ctrl_writeEnable, ctrl_writeReg, data_writeReg, trace_ready,
    output trace_valid, trace_cycle, trace_reg, trace_data, fill_level, drop_count, overflow
  );

  modport master (
    output trace_enable, clear, ctrl_writeEnable, ctrl_writeReg, data_writeReg, trace_ready,
    input  trace_valid, trace_cycle, trace_reg, trace_data, fill_level, drop_count, overflow
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: cycle-stamped FIFO of register-file writebacks drained over valid/ready.
// Optional macro WB_TRACE_DEDUP_EN suppresses a capture identical to the previous capture.
module wb_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16,
  parameter int DROP_W  = 8
) (
  input logic              clock,
  input logic              reset,
  wb_trace_buffer_if.slave bus
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = CYCLE_W + 5 + 32;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wrPtr;
  logic [ADDR_W-1:0]  r_rdPtr;
  logic [ADDR_W:0]    r_fill;
  logic [CYCLE_W-1:0] r_cycle;
  logic [DROP_W-1:0]  r_drops;
  logic               r_overflow;

  logic               w_qualified;
  logic               w_capture;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;

  assign w_qualified = bus.trace_enable && bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);

`ifdef WB_TRACE_DEDUP_EN
  logic        r_lastValid;
  logic [4:0]  r_lastReg;
  logic [31:0] r_lastData;
  logic        w_dup;

  assign w_dup     = r_lastValid && (r_lastReg == bus.ctrl_writeReg) && (r_lastData == bus.data_writeReg);
  assign w_capture = w_qualified && !w_dup;

  // Remembers the last capture whether it was queued or dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lastValid <= 1'b0;
      r_lastReg   <= 5'd0;
      r_lastData  <= 32'd0;
    end else if (bus.clear) begin
      r_lastValid <= 1'b0;
    end else if (w_capture) begin
      r_lastValid <= 1'b1;
      r_lastReg   <= bus.ctrl_writeReg;
      r_lastData  <= bus.data_writeReg;
    end
  end
`else
  assign w_capture = w_qualified;
`endif

  assign w_full = (r_fill == (ADDR_W + 1)'(DEPTH));
  assign w_pop  = (r_fill != '0) && bus.trace_ready;
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && w_full && !w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + CYCLE_W'(1);
    end
  end

  // Clear outranks push and pop; a full FIFO with a pop still accepts the push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_fill     <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_fill     <= '0;
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + ADDR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + ADDR_W'(1);
      if (w_push && !w_pop) begin
        r_fill <= r_fill + (ADDR_W + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_fill <= r_fill - (ADDR_W + 1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != '1) r_drops <= r_drops + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !bus.clear) begin
      r_mem[r_wrPtr] <= {r_cycle, bus.ctrl_writeReg, bus.data_writeReg};
    end
  end

  // Head fields are forced to zero while empty so reset and idle outputs read 0.
  assign w_head          = r_mem[r_rdPtr];
  assign bus.trace_valid = (r_fill != '0);
  assign bus.trace_cycle = bus.trace_valid ? w_head[ENTRY_W-1 -: CYCLE_W] : '0;
  assign bus.trace_reg   = bus.trace_valid ? w_head[36:32] : 5'd0;
  assign bus.trace_data  = bus.trace_valid ? w_head[31:0] : 32'd0;
  assign bus.fill_level  = r_fill;
  assign bus.drop_count  = r_drops;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: table vectors, directed corner sequences and random traffic checked
// against a queue-based reference model; a second small instance covers stamp wrap and drop saturation.
module tb_wb_trace_buffer;
  localparam int DEPTH     = 16;
  localparam int CYCLE_W   = 16;
  localparam int DROP_W    = 8;
  localparam int S_DEPTH   = 4;
  localparam int S_CYCLE_W = 4;
  localparam int S_DROP_W  = 2;

  logic clock = 1'b0;
  logic reset;
  logic smallReset;

  always #5 clock = ~clock;

  wb_trace_buffer_if #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .DROP_W(DROP_W)) bus ();
  wb_trace_buffer_if #(.DEPTH(S_DEPTH), .CYCLE_W(S_CYCLE_W), .DROP_W(S_DROP_W)) smallBus ();

  wb_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  wb_trace_buffer #(.DEPTH(S_DEPTH), .CYCLE_W(S_CYCLE_W), .DROP_W(S_DROP_W)) smallDut (
    .clock(clock), .reset(smallReset), .bus(smallBus)
  );

  typedef struct {
    int unsigned cycle;
    int unsigned regNum;
    int unsigned data;
  } rec_t;

  typedef struct {
    bit          en;
    bit          we;
    int unsigned regNum;
    int unsigned data;
    bit          ready;
    bit          clr;
    bit          expValid;
    int unsigned expCycle;
    int unsigned expReg;
    int unsigned expData;
    int unsigned expFill;
  } vec_t;

  rec_t        modelQ[$];
  int unsigned modelCycle;
  int unsigned modelDrops;
  bit          modelOverflow;
  bit          lastValid;
  int unsigned lastReg;
  int unsigned lastData;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit we, input int unsigned regNum,
                               input int unsigned data, input bit ready, input bit clr);
    bus.trace_enable     = en;
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = regNum[4:0];
    bus.data_writeReg    = data;
    bus.trace_ready      = ready;
    bus.clear            = clr;
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelCycle    = 0;
    modelDrops    = 0;
    modelOverflow = 1'b0;
    lastValid     = 1'b0;
  endtask

  // What one rising edge does to the trace, from the currently driven inputs.
  task automatic modelEdge();
    bit   cap;
    bit   pop;
    rec_t r;
    cap = bus.trace_enable && bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
`ifdef WB_TRACE_DEDUP_EN
    if (cap && lastValid && lastReg == bus.ctrl_writeReg && lastData == bus.data_writeReg) cap = 1'b0;
`endif
    if (bus.clear) begin
      modelQ.delete();
      modelDrops    = 0;
      modelOverflow = 1'b0;
      lastValid     = 1'b0;
    end else begin
      pop = (modelQ.size() != 0) && bus.trace_ready;
      if (pop) r = modelQ.pop_front();
      if (cap) begin
        lastValid = 1'b1;
        lastReg   = bus.ctrl_writeReg;
        lastData  = bus.data_writeReg;
        if (modelQ.size() < DEPTH) begin
          r.cycle  = modelCycle;
          r.regNum = bus.ctrl_writeReg;
          r.data   = bus.data_writeReg;
          modelQ.push_back(r);
        end else begin
          modelOverflow = 1'b1;
          if (modelDrops < (2 ** DROP_W) - 1) modelDrops++;
        end
      end
    end
    modelCycle = (modelCycle + 1) % (2 ** CYCLE_W);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, " valid"}, bus.trace_valid, modelQ.size() != 0);
    checkOutput({tag, " fill"}, bus.fill_level, modelQ.size());
    checkOutput({tag, " drops"}, bus.drop_count, modelDrops);
    checkOutput({tag, " overflow"}, bus.overflow, modelOverflow);
    if (modelQ.size() != 0) begin
      checkOutput({tag, " cycle"}, bus.trace_cycle, modelQ[0].cycle);
      checkOutput({tag, " reg"}, bus.trace_reg, modelQ[0].regNum);
      checkOutput({tag, " data"}, bus.trace_data, modelQ[0].data);
    end
  endtask

  vec_t vecs[10];

  initial begin
    int unsigned clearStamp;
    int unsigned expN;
    int unsigned expData[3];

    vecs[0] = '{1'b0, 1'b0, 0, 0,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};
    vecs[1] = '{1'b0, 1'b0, 0, 0,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};
    vecs[2] = '{1'b0, 1'b0, 0, 0,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};
    vecs[3] = '{1'b1, 1'b1, 5, 7,  1'b1, 1'b0, 1'b1, 3, 5, 7,  1};
    vecs[4] = '{1'b1, 1'b1, 0, 9,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};
    vecs[5] = '{1'b0, 1'b1, 7, 1,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};
    vecs[6] = '{1'b1, 1'b0, 8, 2,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};
    vecs[7] = '{1'b1, 1'b1, 9, 99, 1'b0, 1'b0, 1'b1, 7, 9, 99, 1};
    vecs[8] = '{1'b1, 1'b0, 0, 0,  1'b0, 1'b0, 1'b1, 7, 9, 99, 1};
    vecs[9] = '{1'b0, 1'b0, 0, 0,  1'b1, 1'b0, 1'b0, 0, 0, 0,  0};

    reset      = 1'b0;
    smallReset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    smallBus.trace_enable     = 1'b0;
    smallBus.ctrl_writeEnable = 1'b0;
    smallBus.ctrl_writeReg    = 5'd0;
    smallBus.data_writeReg    = 32'd0;
    smallBus.trace_ready      = 1'b0;
    smallBus.clear            = 1'b0;
    modelReset();
    repeat (3) @(posedge clock);
    #1;

    checkOutput("reset valid", bus.trace_valid, 0);
    checkOutput("reset fill", bus.fill_level, 0);
    checkOutput("reset drops", bus.drop_count, 0);
    checkOutput("reset overflow", bus.overflow, 0);
    checkOutput("reset cycle", bus.trace_cycle, 0);
    checkOutput("reset reg", bus.trace_reg, 0);
    checkOutput("reset data", bus.trace_data, 0);
    checkOutput("small reset valid", smallBus.trace_valid, 0);

    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en, vecs[i].we, vecs[i].regNum, vecs[i].data, vecs[i].ready, vecs[i].clr);
      tick();
      checkOutput($sformatf("vec%0d valid", i), bus.trace_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d fill", i), bus.fill_level, vecs[i].expFill);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d cycle", i), bus.trace_cycle, vecs[i].expCycle);
        checkOutput($sformatf("vec%0d reg", i), bus.trace_reg, vecs[i].expReg);
        checkOutput($sformatf("vec%0d data", i), bus.trace_data, vecs[i].expData);
      end
    end

    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1, 1, k, k * 10, 0, 0);
      tick();
    end
    checkOutput("full fill", bus.fill_level, 16);
    checkOutput("full drops", bus.drop_count, 2);
    checkOutput("full overflow", bus.overflow, 1);
    checkOutput("full head reg", bus.trace_reg, 1);
    checkOutput("full head data", bus.trace_data, 10);
    checkAgainstModel("full");

    applyStimulus(1, 1, 20, 200, 1, 0);
    tick();
    checkOutput("full pushpop fill", bus.fill_level, 16);
    checkOutput("full pushpop drops", bus.drop_count, 2);
    checkOutput("full pushpop head reg", bus.trace_reg, 2);

    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int k = 2; k <= 16; k++) begin
      checkOutput($sformatf("drain reg r%0d", k), bus.trace_reg, k);
      checkOutput($sformatf("drain data r%0d", k), bus.trace_data, k * 10);
      tick();
    end
    checkOutput("drain last reg", bus.trace_reg, 20);
    checkOutput("drain last data", bus.trace_data, 200);
    tick();
    checkOutput("drained valid", bus.trace_valid, 0);
    checkAgainstModel("drained");

    for (int k = 21; k <= 25; k++) begin
      applyStimulus(1, 1, k, k, 0, 0);
      tick();
    end
    checkOutput("preclear fill", bus.fill_level, 5);
    checkOutput("preclear drops", bus.drop_count, 2);
    clearStamp = modelCycle;
    applyStimulus(1, 1, 26, 260, 0, 1);
    tick();
    checkOutput("clear fill", bus.fill_level, 0);
    checkOutput("clear valid", bus.trace_valid, 0);
    checkOutput("clear drops", bus.drop_count, 0);
    checkOutput("clear overflow", bus.overflow, 0);
    applyStimulus(1, 1, 27, 270, 0, 0);
    tick();
    checkOutput("postclear cycle", bus.trace_cycle, (clearStamp + 1) % (2 ** CYCLE_W));
    checkOutput("postclear reg", bus.trace_reg, 27);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkAgainstModel("postclear drain");

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 42, 0, 0);
    tick();
    tick();
    applyStimulus(1, 1, 3, 43, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
`ifdef WB_TRACE_DEDUP_EN
    expN = 2;
    expData[0] = 42; expData[1] = 43; expData[2] = 0;
`else
    expN = 3;
    expData[0] = 42; expData[1] = 42; expData[2] = 43;
`endif
    checkOutput("dedup fill", bus.fill_level, expN);
    checkOutput("dedup drops", bus.drop_count, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < int'(expN); i++) begin
      checkOutput($sformatf("dedup data%0d", i), bus.trace_data, expData[i]);
      tick();
    end
    checkOutput("dedup drained", bus.trace_valid, 0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4),
                    $urandom_range(0, 2),
                    (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 59) == 0);
      tick();
      checkAgainstModel($sformatf("rand%0d", n));
    end

    applyStimulus(0, 0, 0, 0, 1, 0);
    repeat (20) tick();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 1, k + 10, k, 0, 0);
      tick();
    end
    checkOutput("prereset fill", bus.fill_level, 3);
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset valid", bus.trace_valid, 0);
    checkOutput("midreset fill", bus.fill_level, 0);
    checkOutput("midreset cycle", bus.trace_cycle, 0);
    checkOutput("midreset data", bus.trace_data, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(1, 1, 6, 66, 0, 0);
    tick();
    checkOutput("afterreset cycle", bus.trace_cycle, 0);
    checkOutput("afterreset reg", bus.trace_reg, 6);
    checkAgainstModel("afterreset");

    applyStimulus(0, 0, 0, 0, 1, 0);
    smallReset = 1'b1;
    repeat (15) tick();
    smallBus.trace_enable     = 1'b1;
    smallBus.ctrl_writeEnable = 1'b1;
    smallBus.ctrl_writeReg    = 5'd1;
    smallBus.data_writeReg    = 32'd1;
    tick();
    smallBus.ctrl_writeReg    = 5'd2;
    smallBus.data_writeReg    = 32'd2;
    tick();
    smallBus.ctrl_writeEnable = 1'b0;
    checkOutput("wrap fill", smallBus.fill_level, 2);
    checkOutput("wrap first stamp", smallBus.trace_cycle, 15);
    smallBus.trace_ready = 1'b1;
    tick();
    smallBus.trace_ready = 1'b0;
    checkOutput("wrap second stamp", smallBus.trace_cycle, 0);
    checkOutput("wrap second reg", smallBus.trace_reg, 2);
    smallBus.ctrl_writeEnable = 1'b1;
    for (int k = 3; k <= 10; k++) begin
      smallBus.ctrl_writeReg = k[4:0];
      smallBus.data_writeReg = k;
      tick();
    end
    smallBus.ctrl_writeEnable = 1'b0;
    checkOutput("sat fill", smallBus.fill_level, 4);
    checkOutput("sat drops", smallBus.drop_count, 3);
    checkOutput("sat overflow", smallBus.overflow, 1);
    checkOutput("sat head untouched", smallBus.trace_reg, 2);
    smallBus.clear = 1'b1;
    tick();
    smallBus.clear = 1'b0;
    checkOutput("small clear drops", smallBus.drop_count, 0);
    checkOutput("small clear fill", smallBus.fill_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Synthesizable capture buffer that sits directly downstream of the processor's register-file write port.
- Snoops each writeback (enable, register, data), tags it with a free-running cycle stamp, and queues it in a FIFO.
- Queued records drain over a valid/ready stream to a logger or UART bridge.
- Gives on-board hardware the same "Cycle N: wrote X into register R" trace the simulation harness produces.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
CYCLE_W, 16, width of cycle stamp counter
DROP_W, 8, width of saturating dropped-record counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
trace_enable  input  1  capture qualifier; 0 = ignore writebacks
clear  input  1  synchronous flush of FIFO, drop counter and overflow flag
ctrl_writeEnable  input  1  regfile write enable from processor
ctrl_writeReg  input  5  regfile destination register
data_writeReg  input  32  regfile write data
trace_valid  output  1  head record available
trace_ready  input  1  consumer accepts head record
trace_cycle  output  CYCLE_W  cycle stamp of head record
trace_reg  output  5  register of head record
trace_data  output  32  data of head record
fill_level  output  log2(DEPTH)+1  entries currently stored
drop_count  output  DROP_W  records lost to full FIFO, saturating
overflow  output  1  sticky: at least one record dropped

Behaviour:
- Reset (reset low, asynchronous): pointers, fill_level, cycle counter, drop_count and overflow all go to 0. trace_valid = 0. trace_cycle, trace_reg and trace_data read 0.
- Cycle counter:
  - Increments by 1 every clock after reset deasserts; wraps from 2^CYCLE_W-1 to 0.
  - A record's stamp is the counter value at the capturing edge.
  - The first edge after reset stamps 0.
- Capture condition: trace_enable && ctrl_writeEnable && ctrl_writeReg != 0, sampled at the rising edge. Writes to r0 are never captured.
- Latency:
  - A captured record is written into the FIFO at the capturing edge.
  - trace_valid rises immediately after that edge, i.e. the record is visible in the following cycle.
  - There is no combinational bypass from input to output.
- Output stream:
  - trace_valid = (fill_level != 0).
  - trace_cycle, trace_reg and trace_data show the head entry and hold stable while valid && !ready.
  - A pop occurs at any edge where trace_valid && trace_ready.
- Full FIFO:
  - A capture with no simultaneous pop is dropped.
  - drop_count increments, saturating at 2^DROP_W-1, and overflow sets.
  - Existing entries are untouched.
- Simultaneous push and pop when full: the pop frees a slot, the push is accepted, fill_level stays at DEPTH, and nothing is counted as a drop.
- Simultaneous push and pop when empty: the pop is impossible (valid = 0). The push is accepted and fill_level becomes 1.
- Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH inclusive.
- clear:
  - Takes priority over push and pop in the same cycle; a capture in that cycle is discarded.
  - Zeroes the pointers, fill_level, drop_count and overflow.
  - Does not reset the cycle counter.
- trace_enable low: no captures, but the cycle counter keeps running and the drain continues normally.
- Reset mid-operation: all queued records are lost; the counter restarts at 0 once reset is released.

Optional Feature:
WB_TRACE_DEDUP_EN
- Defined:
  - A last-captured (reg, data) register is kept; it is cleared to invalid by reset and by clear.
  - A capture whose reg and data both equal the last captured record is suppressed. It is not enqueued, is not a drop, and does not touch drop_count.
  - The comparison is against the last accepted-or-dropped capture, not the FIFO head.
- Undefined: every qualifying writeback is captured; no comparison logic is present.

Test Plan:
- Reset, then writes r5=7 at stamp 3 and r0=9 at stamp 4, ready held 1 -> exactly one record {cycle 3, reg 5, data 7}; trace_valid high for one cycle; r0 never appears.
- ready=0, 18 consecutive captures r1..r18 with data=reg*10, DEPTH 16 -> fill_level 16, drop_count 2, overflow 1; draining yields r1..r16 in order with data 10..160.
- FIFO full, ready=1, capture in the same cycle -> fill_level stays 16, drop_count unchanged, new record appears last.
- FIFO holding 5 entries, clear asserted together with a capture -> fill_level 0, trace_valid 0, drop_count 0, overflow 0; the next capture's stamp continues the counter.
- CYCLE_W=4, capture at counter 15 then the next edge -> stamps 15 then 0 (wrap).
- WB_TRACE_DEDUP_EN defined, writes r3=42, r3=42, r3=43 -> two records (42, 43), drop_count 0; undefined -> three records.
